// File: rtl/frv_mem_arbiter_pkg.sv
// frv_mem_arbiter_pkg: source IDs, limits and helpers shared by the memory arbiter.
package frv_mem_arbiter_pkg;

    // Identifies which core channel owns a bus transaction.
    typedef enum logic {
        FRV_SRC_IMEM = 1'b0,
        FRV_SRC_DMEM = 1'b1
    } frv_src_e;

    // Upper bound on the OUTSTANDING parameter of frv_mem_arbiter.
    localparam int unsigned FRV_MEM_ARB_MAX_OUTSTANDING = 4;

    // The source that is not s; used by round-robin selection.
    function automatic frv_src_e frv_src_other(input frv_src_e s);
        return (s == FRV_SRC_IMEM) ? FRV_SRC_DMEM : FRV_SRC_IMEM;
    endfunction

endpackage

// File: rtl/frv_mem_arbiter_idq.sv
// frv_arb_idq: in-order FIFO of 1-bit source IDs for outstanding bus transactions.
// A push while full is accepted only when a pop happens in the same cycle.
module frv_arb_idq
    import frv_mem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic     g_clk,
    input  logic     g_reset,
    input  logic     push,
    input  frv_src_e push_id,
    input  logic     pop,
    output frv_src_e head,
    output logic     full,
    output logic     empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DEPTH-1:0] id_q, id_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign head  = frv_src_e'(id_q[rd_ptr_q]);

    // Next-state for storage, wrapping pointers and occupancy count.
    always_comb begin
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        id_d     = id_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            id_d[wr_ptr_q] = push_id;
            wr_ptr_d       = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Queue state registers, cleared asynchronously.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            id_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            id_q     <= id_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/frv_mem_arbiter.sv
// frv_mem_arbiter: merges the core's imem/dmem channels onto one memory bus.
// Optional feature macro FRV_MEM_ARB_RR_EN selects round-robin arbitration;
// without it DMEM has fixed priority over IMEM.
module frv_mem_arbiter
    import frv_mem_arbiter_pkg::*;
#(
    parameter int unsigned OUTSTANDING = 2,
    parameter int unsigned XL          = 31
) (
    input  logic          g_clk,
    input  logic          g_reset,

    input  logic          imem_req,
    input  logic          imem_wen,
    input  logic [3:0]    imem_strb,
    input  logic [XL:0]   imem_wdata,
    input  logic [XL:0]   imem_addr,
    output logic          imem_gnt,
    output logic          imem_recv,
    output logic          imem_error,
    output logic [XL:0]   imem_rdata,
    input  logic          imem_ack,

    input  logic          dmem_req,
    input  logic          dmem_wen,
    input  logic [3:0]    dmem_strb,
    input  logic [XL:0]   dmem_wdata,
    input  logic [XL:0]   dmem_addr,
    output logic          dmem_gnt,
    output logic          dmem_recv,
    output logic          dmem_error,
    output logic [XL:0]   dmem_rdata,
    input  logic          dmem_ack,

    output logic          mem_req,
    output logic          mem_wen,
    output logic [3:0]    mem_strb,
    output logic [XL:0]   mem_wdata,
    output logic [XL:0]   mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_recv,
    input  logic          mem_error,
    input  logic [XL:0]   mem_rdata,
    output logic          mem_ack,

    output logic          spurious_resp
);

    frv_src_e sel;
    frv_src_e lock_src_q, lock_src_d;
    frv_src_e last_src_q, last_src_d;
    frv_src_e q_head;
    logic     lock_v_q, lock_v_d;
    logic     spurious_q, spurious_d;
    logic     sel_req, accept;
    logic     q_full, q_empty, q_pop;

    // Source selection: a stalled request stays locked, otherwise apply policy.
    always_comb begin
        sel = FRV_SRC_IMEM;
        if (lock_v_q) begin
            sel = lock_src_q;
        end else if (imem_req && dmem_req) begin
`ifdef FRV_MEM_ARB_RR_EN
            sel = frv_src_other(last_src_q);
`else
            sel = FRV_SRC_DMEM;
`endif
        end else if (dmem_req) begin
            sel = FRV_SRC_DMEM;
        end
    end

    // Request forwarding and grant; a pop in the same cycle frees a full slot,
    // so a new request may still go out while the queue is full.
    always_comb begin
        if (sel == FRV_SRC_DMEM) begin
            sel_req   = dmem_req;
            mem_wen   = dmem_wen;
            mem_strb  = dmem_strb;
            mem_wdata = dmem_wdata;
            mem_addr  = dmem_addr;
        end else begin
            sel_req   = imem_req;
            mem_wen   = imem_wen;
            mem_strb  = imem_strb;
            mem_wdata = imem_wdata;
            mem_addr  = imem_addr;
        end
        mem_req  = sel_req && (!q_full || q_pop);
        accept   = mem_req && mem_gnt;
        imem_gnt = accept && (sel == FRV_SRC_IMEM);
        dmem_gnt = accept && (sel == FRV_SRC_DMEM);
    end

    // Response routing by queue head; with an empty queue responses are discarded.
    always_comb begin
        imem_recv  = 1'b0;
        imem_error = 1'b0;
        imem_rdata = '0;
        dmem_recv  = 1'b0;
        dmem_error = 1'b0;
        dmem_rdata = '0;
        mem_ack    = 1'b0;
        if (!q_empty) begin
            if (q_head == FRV_SRC_IMEM) begin
                imem_recv  = mem_recv;
                imem_error = mem_error;
                imem_rdata = mem_rdata;
                mem_ack    = imem_ack;
            end else begin
                dmem_recv  = mem_recv;
                dmem_error = mem_error;
                dmem_rdata = mem_rdata;
                mem_ack    = dmem_ack;
            end
        end else begin
            mem_ack = mem_recv;
        end
        q_pop = mem_recv && mem_ack && !q_empty;
    end

    // Next-state for lock, last accepted source and sticky spurious flag.
    always_comb begin
        lock_v_d   = lock_v_q;
        lock_src_d = lock_src_q;
        last_src_d = last_src_q;
        spurious_d = spurious_q || (mem_recv && q_empty);
        if (accept) begin
            lock_v_d   = 1'b0;
            last_src_d = sel;
        end else if (mem_req) begin
            lock_v_d   = 1'b1;
            lock_src_d = sel;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            lock_v_q   <= 1'b0;
            lock_src_q <= FRV_SRC_IMEM;
            last_src_q <= FRV_SRC_IMEM;
            spurious_q <= 1'b0;
        end else begin
            lock_v_q   <= lock_v_d;
            lock_src_q <= lock_src_d;
            last_src_q <= last_src_d;
            spurious_q <= spurious_d;
        end
    end

    assign spurious_resp = spurious_q;

    frv_arb_idq #(
        .DEPTH(OUTSTANDING)
    ) u_idq (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .push    (accept),
        .push_id (sel),
        .pop     (q_pop),
        .head    (q_head),
        .full    (q_full),
        .empty   (q_empty)
    );

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// tb_frv_mem_arbiter: vector table plus hand sequences for lock, spurious and reset.
module tb_frv_mem_arbiter;
    import frv_mem_arbiter_pkg::*;

    localparam logic [31:0] IA = 32'h8000_0000;
    localparam logic [31:0] DA = 32'h1000_0040;
`ifdef FRV_MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        imem_req, imem_wen, imem_gnt, imem_recv, imem_error, imem_ack;
    logic [3:0]  imem_strb;
    logic [31:0] imem_wdata, imem_addr, imem_rdata;
    logic        dmem_req, dmem_wen, dmem_gnt, dmem_recv, dmem_error, dmem_ack;
    logic [3:0]  dmem_strb;
    logic [31:0] dmem_wdata, dmem_addr, dmem_rdata;
    logic        mem_req, mem_wen, mem_gnt, mem_recv, mem_error, mem_ack;
    logic [3:0]  mem_strb;
    logic [31:0] mem_wdata, mem_addr, mem_rdata;
    logic        spurious_resp;

    int n_vec = 0;
    int n_err = 0;
    int n_chk = 0;
    frv_src_e sb[$];

    typedef struct {
        logic        ir, dr, gnt, rv, ack;
        logic [31:0] rd;
        logic        e_mreq, e_ig, e_dg, e_ir, e_dr, e_mack;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl[12];

    frv_mem_arbiter #(
        .OUTSTANDING(2),
        .XL(31)
    ) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .imem_req(imem_req), .imem_wen(imem_wen), .imem_strb(imem_strb),
        .imem_wdata(imem_wdata), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_recv(imem_recv), .imem_error(imem_error), .imem_rdata(imem_rdata),
        .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
        .dmem_wdata(dmem_wdata), .dmem_addr(dmem_addr), .dmem_gnt(dmem_gnt),
        .dmem_recv(dmem_recv), .dmem_error(dmem_error), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_strb(mem_strb),
        .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_recv(mem_recv), .mem_error(mem_error), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack),
        .spurious_resp(spurious_resp)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic dr, input logic gnt,
                         input logic rv, input logic ack, input logic [31:0] rd);
        imem_req   = ir;
        imem_wen   = 1'b0;
        imem_strb  = ir ? 4'hF : 4'h0;
        imem_wdata = '0;
        imem_addr  = ir ? IA : '0;
        dmem_req   = dr;
        dmem_wen   = dr;
        dmem_strb  = dr ? 4'h3 : 4'h0;
        dmem_wdata = dr ? 32'hCAFE_F00D : '0;
        dmem_addr  = dr ? DA : '0;
        mem_gnt    = gnt;
        mem_recv   = rv;
        mem_rdata  = rv ? rd : '0;
        mem_error  = rv & rd[0];
        imem_ack   = ack;
        dmem_ack   = ack;
    endtask

    task automatic sample();
        @(negedge g_clk);
        n_vec++;
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    // Pops the expected owner of a response when the DUT presents one.
    task automatic sb_check();
        frv_src_e e;
        if (imem_recv || dmem_recv) begin
            chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("resp_src_dmem", 32'(dmem_recv), 32'(e == FRV_SRC_DMEM));
                chk("resp_src_imem", 32'(imem_recv), 32'(e == FRV_SRC_IMEM));
                if (e == FRV_SRC_IMEM) begin
                    chk("imem_rdata", imem_rdata, mem_rdata);
                    chk("imem_error", 32'(imem_error), 32'(mem_error));
                    chk("dmem_rdata_zero", dmem_rdata, 32'd0);
                    chk("dmem_error_zero", 32'(dmem_error), 32'd0);
                end else begin
                    chk("dmem_rdata", dmem_rdata, mem_rdata);
                    chk("dmem_error", 32'(dmem_error), 32'(mem_error));
                    chk("imem_rdata_zero", imem_rdata, 32'd0);
                    chk("imem_error_zero", 32'(imem_error), 32'd0);
                end
            end
        end
    endtask

    function automatic vec_t mk(input logic ir, input logic dr, input logic gnt,
                                input logic rv, input logic ack, input logic [31:0] rd,
                                input logic em, input logic eig, input logic edg,
                                input logic eir, input logic edr, input logic emack,
                                input logic [31:0] ea);
        vec_t v;
        v.ir = ir; v.dr = dr; v.gnt = gnt; v.rv = rv; v.ack = ack; v.rd = rd;
        v.e_mreq = em; v.e_ig = eig; v.e_dg = edg; v.e_ir = eir; v.e_dr = edr;
        v.e_mack = emack; v.e_addr = ea;
        return v;
    endfunction

    initial begin
        vec_t v;
        //            ir dr gn rv ak rdata           mreq ig   dg   ir   dr   mack addr
        tbl[0]  = mk(0, 0, 0, 0, 0, 32'h0,          0,   0,   0,   0,   0,   0,   32'h0);
        tbl[1]  = mk(1, 0, 1, 0, 0, 32'h0,          1,   1,   0,   0,   0,   0,   IA);
        tbl[2]  = mk(0, 0, 1, 1, 1, 32'hDEAD_BEEF,  0,   0,   0,   1,   0,   1,   32'h0);
        tbl[3]  = mk(1, 1, 1, 0, 0, 32'h0,          1,   0,   1,   0,   0,   0,   DA);
        tbl[4]  = mk(1, 1, 1, 1, 1, 32'h1111_0001,  1,   RR,  !RR, 0,   1,   1,   RR ? IA : DA);
        tbl[5]  = mk(1, 1, 1, 0, 0, 32'h0,          1,   0,   1,   0,   0,   0,   DA);
        tbl[6]  = mk(1, 1, 1, 0, 0, 32'h0,          0,   0,   0,   0,   0,   0,   RR ? IA : DA);
        tbl[7]  = mk(1, 1, 1, 1, 1, 32'h2222_0002,  1,   RR,  !RR, RR,  !RR, 1,   RR ? IA : DA);
        tbl[8]  = mk(1, 1, 1, 0, 0, 32'h0,          0,   0,   0,   0,   0,   0,   DA);
        tbl[9]  = mk(0, 0, 0, 1, 1, 32'h3333_0003,  0,   0,   0,   0,   1,   1,   32'h0);
        tbl[10] = mk(0, 0, 0, 1, 1, 32'h4444_0005,  0,   0,   0,   RR,  !RR, 1,   32'h0);
        tbl[11] = mk(0, 0, 0, 0, 0, 32'h0,          0,   0,   0,   0,   0,   0,   32'h0);

        g_reset = 1'b1;
        drive(0, 0, 0, 0, 0, 32'h0);
        repeat (2) @(posedge g_clk);
        #1 g_reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            v = tbl[i];
            drive(v.ir, v.dr, v.gnt, v.rv, v.ack, v.rd);
            sample();
            chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(v.e_mreq));
            chk($sformatf("v%0d_imem_gnt", i), 32'(imem_gnt), 32'(v.e_ig));
            chk($sformatf("v%0d_dmem_gnt", i), 32'(dmem_gnt), 32'(v.e_dg));
            chk($sformatf("v%0d_imem_recv", i), 32'(imem_recv), 32'(v.e_ir));
            chk($sformatf("v%0d_dmem_recv", i), 32'(dmem_recv), 32'(v.e_dr));
            chk($sformatf("v%0d_mem_ack", i), 32'(mem_ack), 32'(v.e_mack));
            chk($sformatf("v%0d_mem_addr", i), mem_addr, v.e_addr);
            chk($sformatf("v%0d_mem_wen", i), 32'(mem_wen), 32'(v.e_addr == DA));
            chk($sformatf("v%0d_mem_strb", i), 32'(mem_strb),
                (v.e_addr == DA) ? 32'h3 : ((v.e_addr == IA) ? 32'hF : 32'h0));
            chk($sformatf("v%0d_spurious", i), 32'(spurious_resp), 32'd0);
            sb_check();
            if (v.e_ig) sb.push_back(FRV_SRC_IMEM);
            if (v.e_dg) sb.push_back(FRV_SRC_DMEM);
            tick();
        end

        // Stalled IMEM request must hold the bus fields while DMEM rises.
        drive(1, 0, 0, 0, 0, 32'h0);
        sample();
        chk("lock_c1_req", 32'(mem_req), 32'd1);
        chk("lock_c1_addr", mem_addr, IA);
        chk("lock_c1_gnt", 32'(imem_gnt), 32'd0);
        tick();
        for (int c = 2; c <= 3; c++) begin
            drive(1, 1, 0, 0, 0, 32'h0);
            sample();
            chk($sformatf("lock_c%0d_addr", c), mem_addr, IA);
            chk($sformatf("lock_c%0d_dgnt", c), 32'(dmem_gnt), 32'd0);
            tick();
        end
        drive(1, 1, 1, 0, 0, 32'h0);
        sample();
        chk("lock_c4_igrant", 32'(imem_gnt), 32'd1);
        chk("lock_c4_dgrant", 32'(dmem_gnt), 32'd0);
        chk("lock_c4_addr", mem_addr, IA);
        sb.push_back(FRV_SRC_IMEM);
        tick();
        drive(0, 1, 1, 0, 0, 32'h0);
        sample();
        chk("lock_c5_dgrant", 32'(dmem_gnt), 32'd1);
        chk("lock_c5_addr", mem_addr, DA);
        sb.push_back(FRV_SRC_DMEM);
        tick();
        drive(0, 0, 0, 1, 1, 32'hA1A1_0001);
        sample();
        chk("lock_r1_irecv", 32'(imem_recv), 32'd1);
        sb_check();
        tick();
        drive(0, 0, 0, 1, 1, 32'hB2B2_0000);
        sample();
        chk("lock_r2_drecv", 32'(dmem_recv), 32'd1);
        sb_check();
        tick();

        // Response with nothing outstanding.
        drive(0, 0, 0, 1, 0, 32'h5555_AAAA);
        sample();
        chk("spur_mem_ack", 32'(mem_ack), 32'd1);
        chk("spur_irecv", 32'(imem_recv), 32'd0);
        chk("spur_drecv", 32'(dmem_recv), 32'd0);
        chk("spur_flag_pre", 32'(spurious_resp), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        sample();
        chk("spur_flag_set", 32'(spurious_resp), 32'd1);
        chk("spur_idle_ack", 32'(mem_ack), 32'd0);
        tick();
        repeat (3) tick();
        sample();
        chk("spur_flag_sticky", 32'(spurious_resp), 32'd1);
        tick();

        // Reset with two outstanding transactions.
        drive(1, 0, 1, 0, 0, 32'h0);
        sample();
        chk("rst_acc1", 32'(imem_gnt), 32'd1);
        sb.push_back(FRV_SRC_IMEM);
        tick();
        drive(0, 1, 1, 0, 0, 32'h0);
        sample();
        chk("rst_acc2", 32'(dmem_gnt), 32'd1);
        sb.push_back(FRV_SRC_DMEM);
        tick();
        drive(1, 0, 1, 0, 0, 32'h0);
        sample();
        chk("rst_full_blocks", 32'(mem_req), 32'd0);
        #1 g_reset = 1'b1;
        #1;
        chk("rst_async_clear", 32'(mem_req), 32'd1);
        chk("rst_spur_clear", 32'(spurious_resp), 32'd0);
        sb.delete();
        @(posedge g_clk);
        #1 g_reset = 1'b0;
        sample();
        chk("rst_post_grant", 32'(imem_gnt), 32'd1);
        chk("rst_post_addr", mem_addr, IA);
        sb.push_back(FRV_SRC_IMEM);
        tick();
        drive(0, 0, 0, 1, 1, 32'h600D_F00D);
        sample();
        chk("rst_post_irecv", 32'(imem_recv), 32'd1);
        sb_check();
        tick();
        drive(0, 0, 0, 1, 0, 32'h0BAD_0BAD);
        sample();
        chk("rst_late_ack", 32'(mem_ack), 32'd1);
        chk("rst_late_irecv", 32'(imem_recv), 32'd0);
        chk("rst_late_drecv", 32'(dmem_recv), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        sample();
        chk("rst_late_spur", 32'(spurious_resp), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
